hamming_dec: RTL and testbench
==============================

HAMMING_DEC -- requirements
Module: hamming_dec

Interface
REQ-001 The module SHALL have one parameter: CNT_W, default 8, the width of the corrected-error counter (legal range 1..16).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1 bit, meaning the upstream codeword on in_cw is valid.
REQ-005 The module SHALL have port in_cw, input, 7 bits, the Hamming(7,4) codeword; in_cw[k-1] holds code position k.
REQ-006 The module SHALL have port in_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-007 The module SHALL have port out_valid, output, 1 bit, meaning out_data, out_syn and out_err are valid.
REQ-008 The module SHALL have port out_ready, input, 1 bit, meaning downstream accepts the output this cycle.
REQ-009 The module SHALL have port out_data, output, 4 bits, the corrected data nibble.
REQ-010 The module SHALL have port out_syn, output, 3 bits, the syndrome {s4,s2,s1}.
REQ-011 The module SHALL have port out_err, output, 1 bit, set when out_syn is nonzero.
REQ-012 The module SHALL have port clr_cnt, input, 1 bit, a synchronous clear for err_cnt.
REQ-013 The module SHALL have port err_cnt, output, CNT_W bits, the saturating count of accepted words with nonzero syndrome.

Function
REQ-014 Code layout SHALL be as follows:
- Parity bits occupy positions 1, 2 and 4.
- Data bits occupy positions 3 (d0), 5 (d1), 6 (d2) and 7 (d3).
- Parity is even.
REQ-015 Syndrome bits SHALL be computed from the in_cw positions as follows:
- s1 = XOR of positions 1, 3, 5, 7.
- s2 = XOR of positions 2, 3, 6, 7.
- s4 = XOR of positions 4, 5, 6, 7.
REQ-016 Correction SHALL invert code position S = {s4,s2,s1} when S is 1..7, then extract data bits per REQ-014.
- S = 0 SHALL mean no correction.
- Errors in parity positions (S = 1, 2 or 4) SHALL leave data unchanged.
REQ-017 Double-bit errors are not detected; the block SHALL apply single-error correction regardless.
REQ-018 A transfer SHALL occur when in_valid && in_ready at a rising clk edge.
REQ-019 The output register SHALL load out_data, out_syn and out_err from that transfer at the same edge; latency from acceptance to out_valid = 1 cycle.
REQ-020 in_ready SHALL equal (!out_valid || out_ready), combinationally, so one word per cycle streams at full throughput.
REQ-021 The output valid flag SHALL update as follows:
- out_valid SHALL set on a transfer.
- out_valid SHALL clear when out_ready && !transfer.
- out_valid SHALL otherwise hold.
REQ-022 While out_valid && !out_ready, out_data, out_syn, out_err and out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-023 in_cw SHALL be ignored when no transfer occurs.
REQ-024 err_cnt SHALL increment by 1 on each transfer with nonzero syndrome.
REQ-025 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 clr_cnt SHALL set err_cnt to 0 at the next edge.
REQ-027 When clr_cnt and an errored transfer coincide, clr_cnt SHALL win and err_cnt SHALL become 0.
REQ-028 The output register and err_cnt SHALL be the only state; there is no FSM beyond the out_valid flag.

Reset
REQ-029 On rst assertion, independent of clk, the outputs SHALL immediately take these values:
- out_valid = 0.
- out_data = 4'h0.
- out_syn = 3'b000.
- out_err = 0.
- err_cnt = 0.
REQ-030 in_ready SHALL read 1 during and after reset, because out_valid = 0.
REQ-031 A word held in the output register when reset asserts SHALL be discarded.
REQ-032 No transfer SHALL occur while rst is high.
REQ-033 Normal operation SHALL resume at the first rising edge after rst deasserts.

Verification
REQ-034 Clean word: in_cw = 7'h55 accepted, out_ready = 1 -> the next cycle shows out_valid = 1, out_data = 4'b1011, out_syn = 0, out_err = 0, and err_cnt is unchanged.
REQ-035 Single-bit error: in_cw = 7'h75 (position 6 flipped) -> out_data = 4'b1011, out_syn = 3'd6, out_err = 1, err_cnt = 1.
REQ-036 Exhaustive sweep: the bench SHALL use every data nibble 0..15 via a golden encoder, each with no error and with each of 7 single-bit flips (128 words), streamed back-to-back -> all outputs decode to the original nibble, and err_cnt = 112 for CNT_W = 8.
REQ-037 Backpressure: out_ready = 0 for 3 cycles with a word held -> outputs are stable and in_ready = 0; on release, the next word is accepted in the same cycle the held word leaves.
REQ-038 Saturation/clear: with CNT_W = 2, the bench SHALL feed 5 errored words -> err_cnt = 3; then clr_cnt together with an errored transfer -> err_cnt = 0.
REQ-039 Reset mid-stream: the bench SHALL assert rst asynchronously while out_valid = 1 and err_cnt = 5 -> out_valid and err_cnt read 0 before the next clk edge.

Source files
------------

// File: rtl/hamming_dec.sv
// Hamming(7,4) single-error-correcting decoder with a one-deep ready/valid
// output register and a saturating corrected-error counter.
module hamming_dec #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [6:0]       in_cw,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syn,
    output logic             out_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0] syn_c;
    logic [7:0] pos_onehot_c;
    logic [6:0] cw_fix_c;
    logic [3:0] data_c;
    logic       xfer_c;

    // Syndrome over code positions; in_cw[k-1] is position k.
    always_comb begin
        syn_c[0] = in_cw[0] ^ in_cw[2] ^ in_cw[4] ^ in_cw[6];
        syn_c[1] = in_cw[1] ^ in_cw[2] ^ in_cw[5] ^ in_cw[6];
        syn_c[2] = in_cw[3] ^ in_cw[4] ^ in_cw[5] ^ in_cw[6];
    end

    // Bit 0 of the one-hot stands for "no error" and is dropped.
    always_comb begin
        pos_onehot_c = 8'b0000_0001 << syn_c;
        cw_fix_c     = in_cw ^ pos_onehot_c[7:1];
        data_c       = {cw_fix_c[6], cw_fix_c[5], cw_fix_c[4], cw_fix_c[2]};
    end

    assign in_ready = !out_valid || out_ready;
    assign xfer_c   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 4'h0;
            out_syn   <= 3'b000;
            out_err   <= 1'b0;
        end else begin
            if (xfer_c) begin
                out_data <= data_c;
                out_syn  <= syn_c;
                out_err  <= (syn_c != 3'b000);
            end
            if (xfer_c) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Clear has priority over a coincident errored transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (xfer_c && (syn_c != 3'b000) && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_dec.sv
// Directed bench for hamming_dec: an 8-bit-counter instance for decode and
// flow control, and a 2-bit-counter instance sharing the stimulus for saturation.
module tb_hamming_dec;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_cw;
    logic       out_ready;
    logic       clr_cnt;

    logic       in_ready,  out_valid,  out_err;
    logic [3:0] out_data;
    logic [2:0] out_syn;
    logic [7:0] err_cnt;

    logic       in_ready2, out_valid2, out_err2;
    logic [3:0] out_data2;
    logic [2:0] out_syn2;
    logic [1:0] err_cnt2;

    int tests = 0;
    int fails = 0;

    hamming_dec #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cw(in_cw),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syn(out_syn), .out_err(out_err),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt)
    );

    hamming_dec #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cw(in_cw),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_syn(out_syn2), .out_err(out_err2),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Golden encoder: {p7..p1} = {d3,d2,d1,p4,d0,p2,p1}, even parity.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    function automatic logic [6:0] flip(input int pos);
        logic [6:0] m;
        m = 7'b0;
        if (pos != 0) m[pos-1] = 1'b1;
        return m;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cw = 7'h00; out_ready = 1'b1; clr_cnt = 1'b0;

        // Reset state before any clock edge
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_syn",   32'(out_syn),   32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst2_all", {in_ready2, out_valid2, out_err2, out_data2, out_syn2, err_cnt2},
            32'b1_0_0_0000_000_00);
        step(); step();
        rst = 1'b0;

        // Clean word 0x55 -> data 1011
        in_valid = 1'b1; in_cw = 7'h55;
        step();
        in_valid = 1'b0;
        chk("clean_valid", 32'(out_valid), 32'd1);
        chk("clean_data",  32'(out_data),  32'b1011);
        chk("clean_syn",   32'(out_syn),   32'd0);
        chk("clean_err",   32'(out_err),   32'd0);
        chk("clean_cnt",   32'(err_cnt),   32'd0);

        // Position 6 flipped -> syndrome 6, corrected
        in_valid = 1'b1; in_cw = 7'h75;
        step();
        in_valid = 1'b0;
        chk("sbe_data", 32'(out_data), 32'b1011);
        chk("sbe_syn",  32'(out_syn),  32'd6);
        chk("sbe_err",  32'(out_err),  32'd1);
        chk("sbe_cnt",  32'(err_cnt),  32'd1);

        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_cnt", 32'(err_cnt), 32'd0);

        // All nibbles x {no error, each single flip}, back-to-back
        in_valid = 1'b1;
        for (int d = 0; d < 16; d++) begin
            for (int k = 0; k < 8; k++) begin
                in_cw = enc(4'(d)) ^ flip(k);
                step();
                chk("sweep_valid", 32'(out_valid), 32'd1);
                chk("sweep_data",  32'(out_data),  32'(d));
                chk("sweep_syn",   32'(out_syn),   32'(k));
                chk("sweep_err",   32'(out_err),   32'(k != 0));
            end
        end
        in_valid = 1'b0;
        chk("sweep_cnt8", 32'(err_cnt),  32'd112);
        chk("sweep_cnt2", 32'(err_cnt2), 32'd3);
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: hold word A (data 5), word B (data 9, pos 3 flipped) waits
        out_ready = 1'b0;
        in_valid = 1'b1; in_cw = enc(4'd5);
        step();
        in_cw = enc(4'd9) ^ flip(3);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data",  32'(out_data),  32'd5);
            chk("bp_syn",   32'(out_syn),   32'd0);
            chk("bp_ready", 32'(in_ready),  32'd0);
            if (i < 3) step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_data",  32'(out_data),  32'd9);
        chk("bp_next_syn",   32'(out_syn),   32'd3);
        chk("bp_cnt",        32'(err_cnt),   32'd113);

        // Saturation of the 2-bit counter, then clear beating an errored transfer
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_cw = enc(4'(i + 1)) ^ flip(i + 1);
            step();
        end
        chk("sat_cnt2", 32'(err_cnt2), 32'd3);
        chk("sat_cnt8", 32'(err_cnt),  32'd5);
        clr_cnt = 1'b1; in_cw = enc(4'hc) ^ flip(7);
        step();
        clr_cnt = 1'b0; in_valid = 1'b0;
        chk("clrwin_cnt2", 32'(err_cnt2), 32'd0);
        chk("clrwin_cnt8", 32'(err_cnt),  32'd0);
        chk("clrwin_data", 32'(out_data), 32'hc);
        chk("clrwin_err",  32'(out_err),  32'd1);

        // Reset mid-stream with out_valid = 1 and err_cnt = 5
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_cw = enc(4'(i + 8)) ^ flip(i + 2);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_cnt",   32'(err_cnt),   32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_cnt",   32'(err_cnt),   32'd0);
        chk("async_rst_data",  32'(out_data),  32'h0);
        chk("async_rst_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b1; in_cw = 7'h75;
        step();
        chk("rst_no_xfer_valid", 32'(out_valid), 32'd0);
        chk("rst_no_xfer_cnt",   32'(err_cnt),   32'd0);
        rst = 1'b0;
        step();
        in_valid = 1'b0;
        chk("resume_valid", 32'(out_valid), 32'd1);
        chk("resume_data",  32'(out_data),  32'b1011);
        chk("resume_syn",   32'(out_syn),   32'd6);
        chk("resume_cnt",   32'(err_cnt),   32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
